// File: rtl/sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl
//
// Single-port controller between the datalogger CPU memory bus and an external
// 256Kx16 asynchronous SRAM. A one-cycle CPU request (valid/ready handshake)
// becomes a timed SRAM read or write sequence with WAIT_CYCLES extra strobe
// cycles. Every SRAM-facing pin (address, control strobes, data drive enable
// and drive data) comes straight from a flop, so there is no combinational
// path from req_* to the SRAM.
//
// Parameters
//   WAIT_CYCLES   extra read/write strobe cycles (0..7)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   req_valid     CPU request present
//   req_we        1 = write, 0 = read
//   req_be[1:0]   byte enables {upper, lower}
//   req_addr      18-bit word address
//   req_wdata     16-bit write data
//   req_ready     high while idle; request accepted on valid & ready
//   rsp_valid     one-cycle completion pulse
//   rsp_rdata     read data, valid with rsp_valid on reads
//   sram_addr     SRAM address pins
//   sram_dq       SRAM bidirectional data pins
//   sram_control  {ce_n, oe_n, we_n, ub_n, lb_n}, all active-low
// ---------------------------------------------------------------------------
module sram_port_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_be,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic [4:0]  sram_control
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
  localparam logic [4:0] CTRL_IDLE = 5'b11111;

  state_t      state_reg;
  logic [2:0]  wait_cnt_reg;
  logic [1:0]  be_reg;
  logic [17:0] addr_reg;
  logic [15:0] dq_out_reg;
  logic        dq_oe_reg;
  logic [4:0]  control_reg;
  logic        rsp_valid_reg;
  logic [15:0] rsp_rdata_reg;
  logic [15:0] rd_data_next;

  // Read data with disabled bytes forced to zero so the CPU never sees
  // whatever the SRAM left floating on an unselected byte lane.
  always_comb begin
    rd_data_next = 16'h0000;
    if (be_reg[1]) rd_data_next[15:8] = sram_dq[15:8];
    if (be_reg[0]) rd_data_next[7:0]  = sram_dq[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 3'd0;
      be_reg        <= 2'b00;
      addr_reg      <= 18'd0;
      dq_out_reg    <= 16'h0000;
      dq_oe_reg     <= 1'b0;
      control_reg   <= CTRL_IDLE;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 16'h0000;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (req_be == 2'b00) begin
              // Nothing to access: complete without touching the SRAM pins,
              // address included, so the bus stays quiet.
              state_reg     <= ACK;
              rsp_valid_reg <= 1'b1;
            end else begin
              addr_reg <= req_addr;
              be_reg   <= req_be;
              if (req_we) begin
                state_reg   <= WR_SETUP;
                control_reg <= {1'b0, 1'b1, 1'b1, ~req_be};
                dq_out_reg  <= req_wdata;
                dq_oe_reg   <= 1'b1;
              end else begin
                state_reg    <= RD_ACC;
                control_reg  <= {1'b0, 1'b0, 1'b1, ~req_be};
                wait_cnt_reg <= WAIT_LOAD;
              end
            end
          end
        end

        RD_ACC: begin
          if (wait_cnt_reg == 3'd0) begin
            rsp_rdata_reg <= rd_data_next;
            control_reg   <= CTRL_IDLE;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RD_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end

        RD_DONE: state_reg <= IDLE;

        WR_SETUP: begin
          // Address and data have had a full cycle to settle before we_n falls.
          control_reg[2] <= 1'b0;
          wait_cnt_reg   <= WAIT_LOAD;
          state_reg      <= WR_PULSE;
        end

        WR_PULSE: begin
          if (wait_cnt_reg == 3'd0) begin
            control_reg[2] <= 1'b1;
            state_reg      <= WR_HOLD;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end

        WR_HOLD: begin
          // Data was held one cycle past the rising we_n; now release the bus.
          control_reg   <= CTRL_IDLE;
          dq_oe_reg     <= 1'b0;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ACK;
        end

        ACK: state_reg <= IDLE;

        default: begin
          control_reg <= CTRL_IDLE;
          dq_oe_reg   <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign sram_dq      = dq_oe_reg ? dq_out_reg : 16'hzzzz;
  assign sram_addr    = addr_reg;
  assign sram_control = control_reg;
  assign req_ready    = (state_reg == IDLE);
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_rdata    = rsp_rdata_reg;

endmodule
